bus_capture_rx: RTL and testbench
=================================

Name: bus_capture_rx

Overview:
- Receiving end of the shared 8-bit tristate data bus driven by the program counter and other bus drivers.
- On a capture request, waits one settle cycle, then samples the bus into a small FIFO.
- Acknowledges the driver and presents captured words downstream over a valid/ready handshake.
- Sits beside the counter on the datapath bus; feeds address and instruction consumers.

Parameters:
- WIDTH, 8, bus and data word width in bits.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- bus  in  WIDTH  shared tristate bus, read-only here; this block never drives it.
- cap_req  in  1  driver requests a capture; level, held until cap_ack.
- cap_ack  out  1  one-cycle pulse in the cycle the bus word is written.
- out_data  out  WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts out_data when out_valid && out_ready.
- full  out  1  FIFO holds DEPTH words.
- overflow  out  1  sticky: a capture was dropped because the FIFO was full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; FIFO empties. All outputs 0: out_valid, cap_ack, full, overflow, level and out_data.
- FSM states:
  - IDLE: on cap_req=1, go to SETTLE.
  - SETTLE: one cycle for bus turnaround; bus is not sampled. Always go to CAPTURE.
  - CAPTURE: sample bus. If not full, push the word and pulse cap_ack. If full, drop the word, set overflow and still pulse cap_ack so the driver is released. Always go to WAIT_REL.
  - WAIT_REL: stay until cap_req=0, then go to IDLE. This gives exactly one capture per request.
- Latency: cap_req rising edge to cap_ack is 2 cycles (IDLE->SETTLE->CAPTURE).
- Minimum request period is 4 cycles: req, settle, capture, release.
- Data appears on out_data/out_valid the cycle after the push, registered.
- Pop occurs when out_valid && out_ready; head advances next cycle.
- Simultaneous push and pop: allowed in any state.
  - When full, the pop frees a slot, so the push succeeds and overflow is not set.
  - When empty, the push lands and out_valid rises next cycle; the stale head is not popped.
- level equals pushes minus pops. full is asserted when level == DEPTH.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- overflow clears only on rst.
- X or Z on bus is captured as-is; the block does no checking of bus contents.
- cap_req dropping during SETTLE is ignored; the capture still completes.

Optional Feature:
- Macro: BUS_CAPTURE_PARITY_EN.
- Defined:
  - Adds input bus_par (1 bit) and sticky output par_err.
  - In CAPTURE, the even parity of bus is compared with bus_par. On mismatch, par_err is set (sticky until rst), but the word is still pushed.
  - Parity is not stored in the FIFO.
- Undefined: neither port exists, and there is no parity logic.

Decomposition:
- Package bus_pkg holds:
  - the BUS_WIDTH=8 constant;
  - the rx_state_t enum {IDLE, SETTLE, CAPTURE, WAIT_REL}, 2 bits;
  - the default DEPTH constant.
- Sub-module bus_rx_fifo: synchronous FIFO with push/pop, level, full and empty, sized by WIDTH and DEPTH.
- bus_capture_rx keeps the FSM, the overflow and parity flags, and the port wiring.

Test Plan:
- Basic capture:
  - Stimulus: bus=8'hA5, cap_req high at cycle 0, out_ready=0.
  - Required response: cap_ack pulses at cycle 2; out_valid=1 and out_data=A5 at cycle 3; level=1.
- Fill and overflow:
  - Stimulus: out_ready=0; four requests with bus=01,02,03,04, then a fifth with bus=05.
  - Required response: full=1 after the fourth; fifth cap_ack still pulses; overflow=1; level stays 4.
  - Drain: out_ready=1 then yields 01,02,03,04 in order.
- Pop/push collision when full:
  - Stimulus: FIFO full; out_ready=1 in the CAPTURE cycle of a request with bus=3C.
  - Required response: overflow stays 0; level stays 4; 3C emerges after the existing words.
- Request held long:
  - Stimulus: cap_req held high for 10 cycles with bus=7E.
  - Required response: exactly one cap_ack pulse and one push; the FSM sits in WAIT_REL until cap_req falls.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously during SETTLE with 2 words queued.
  - Required response: outputs 0 immediately; after release, level=0 and out_valid=0; overflow=0.
- Parity, only with BUS_CAPTURE_PARITY_EN:
  - Stimulus: bus=8'h03 with bus_par=1.
  - Required response: par_err=1; word 03 is still queued.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus receiver: bus width, default
// FIFO depth and the capture FSM state encoding.
package bus_pkg;

  localparam int BUS_WIDTH     = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURE  = 2'd2,
    WAIT_REL = 2'd3
  } rx_state_t;

endpackage

// File: rtl/bus_rx_fifo.sv
// Synchronous FIFO holding captured bus words. DEPTH must be a power of
// two (>= 2) so the pointers wrap naturally modulo DEPTH. A push while
// full is accepted only if a pop happens in the same cycle. The head word
// reads as zero while empty so the output is clean after reset.
module bus_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);

  // Pointer and occupancy bookkeeping (control only, reset asynchronously).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; data is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/bus_capture_rx.sv
// Receiver for the shared tristate datapath bus. A capture request waits
// one settle cycle for bus turnaround, samples the bus into a FIFO, pulses
// cap_ack, then holds until the request is released so each request gives
// exactly one capture. Captured words go downstream on valid/ready.
// Optional build macro: BUS_CAPTURE_PARITY_EN adds bus_par/par_err.
module bus_capture_rx
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       bus,
  input  logic                   cap_req,
  output logic                   cap_ack,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
`ifdef BUS_CAPTURE_PARITY_EN
  ,
  input  logic                   bus_par,
  output logic                   par_err
`endif
);

  rx_state_t state;
  rx_state_t next_state;
  logic      cap_fire;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;

  // Capture FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; cap_fire marks the single sampling cycle.
  always_comb begin
    next_state = state;
    cap_fire   = 1'b0;
    case (state)
      IDLE:     if (cap_req) next_state = SETTLE;
      SETTLE:   next_state = CAPTURE;
      CAPTURE: begin
        cap_fire   = 1'b1;
        next_state = WAIT_REL;
      end
      WAIT_REL: if (!cap_req) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  assign cap_ack   = cap_fire;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign full      = fifo_full;

  bus_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap_fire),
    .pop   (pop),
    .wdata (bus),
    .rdata (out_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: a capture found the FIFO full with no pop to make room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                overflow <= 1'b0;
    else if (cap_fire && fifo_full && !pop) overflow <= 1'b1;
  end

`ifdef BUS_CAPTURE_PARITY_EN
  // Sticky parity error: even parity of the sampled word disagrees with bus_par.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                par_err <= 1'b0;
    else if (cap_fire && ((^bus) != bus_par)) par_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bus_capture_rx.sv
// Directed bench for bus_capture_rx: a cycle-by-cycle vector table for a
// basic capture plus hand-written sequences for fill/overflow, full-FIFO
// push/pop collision, long-held request, asynchronous reset and parity.
module tb_bus_capture_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus = 8'h00;
  logic       cap_req = 1'b0;
  logic       out_ready = 1'b0;
  logic       cap_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       full;
  logic       overflow;
  logic [2:0] level;
`ifdef BUS_CAPTURE_PARITY_EN
  logic       bus_par = 1'b0;
  logic       par_err;
`endif

  int checks = 0;
  int failures = 0;

  bus_capture_rx #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cap_req   (cap_req),
    .cap_ack   (cap_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .overflow  (overflow),
    .level     (level)
`ifdef BUS_CAPTURE_PARITY_EN
    ,
    .bus_par   (bus_par),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [7:0] bus;
    logic       rdy;
    logic       ack;
    logic       vld;
    logic [7:0] data;
    logic [2:0] lvl;
    logic       full;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_ack"},   cap_ack,   0);
    chk({name, "_full"},  full,      0);
    chk({name, "_ovf"},   overflow,  0);
    chk({name, "_level"}, level,     0);
    chk({name, "_data"},  out_data,  0);
  endtask

  // Pulse reset mid-cycle; called one time unit after a clock edge.
  task automatic do_reset(input string name);
    #1 rst = 1'b1;
    #1 chk_zero(name);
    #1 rst = 1'b0;
    cap_req = 1'b0;
    out_ready = 1'b0;
    step();
  endtask

  // One full request handshake from IDLE; optionally pop in the CAPTURE cycle.
  task automatic request(input logic [7:0] d, input bit pop_at_cap, input string name);
    int n;
    bit got;
    bus = d;
    cap_req = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 6) begin
      step();
      n++;
      if (cap_ack) begin
        got = 1;
        if (pop_at_cap) out_ready = 1'b1;
      end
    end
    chk({name, "_ack_latency"}, got ? n : 32'hFF, 2);
    step();
    out_ready = 1'b0;
    cap_req = 1'b0;
    chk({name, "_ack_single"}, cap_ack, 0);
    step();
  endtask

  // Pop four words back to back and compare them in order.
  task automatic drain(input logic [31:0] words, input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_valid%0d", name, i), out_valid, 1);
      chk($sformatf("%s_data%0d", name, i), out_data, words[31-8*i -: 8]);
      step();
    end
    out_ready = 1'b0;
    chk({name, "_empty"}, out_valid, 0);
    chk({name, "_level0"}, level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    //            req bus    rdy ack vld data   lvl  full
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[2] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[3] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 3'd1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

    // Reset state while rst is held from time zero.
    #1 chk_zero("reset_init");
    step();
    rst = 1'b0;
    step();

    // Basic capture, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      cap_req = vecs[i].req;
      bus = vecs[i].bus;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("basic_c%0d_ack", i),   cap_ack,   vecs[i].ack);
      chk($sformatf("basic_c%0d_valid", i), out_valid, vecs[i].vld);
      chk($sformatf("basic_c%0d_data", i),  out_data,  vecs[i].data);
      chk($sformatf("basic_c%0d_level", i), level,     vecs[i].lvl);
      chk($sformatf("basic_c%0d_full", i),  full,      vecs[i].full);
      chk($sformatf("basic_c%0d_ovf", i),   overflow,  0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;

    // Fill to four entries, then overflow on the fifth.
    for (int i = 1; i <= 4; i++) begin
      request(8'(i), 0, $sformatf("fill%0d", i));
      chk($sformatf("fill%0d_level", i), level, i);
      chk($sformatf("fill%0d_full", i), full, (i == 4) ? 1 : 0);
      chk($sformatf("fill%0d_ovf", i), overflow, 0);
    end
    request(8'h05, 0, "ovf5");
    chk("ovf5_overflow", overflow, 1);
    chk("ovf5_level", level, 4);
    chk("ovf5_full", full, 1);
    drain({8'h01, 8'h02, 8'h03, 8'h04}, "drain_fill");
    chk("ovf_sticky", overflow, 1);

    // Asynchronous reset during SETTLE with two words queued.
    request(8'hA1, 0, "rq1");
    request(8'hA2, 0, "rq2");
    chk("rq_level2", level, 2);
    bus = 8'hA3;
    cap_req = 1'b1;
    step();
    #1 rst = 1'b1;
    #1 chk_zero("reset_mid");
    #1 rst = 1'b0;
    cap_req = 1'b0;
    step();
    chk("post_reset_level", level, 0);
    chk("post_reset_valid", out_valid, 0);
    chk("post_reset_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_reset_noack%0d", i), cap_ack, 0);
      step();
    end
    request(8'h5A, 0, "post_reset_req");
    chk("post_reset_req_data", out_data, 8'h5A);
    chk("post_reset_req_level", level, 1);

    // Push and pop in the same cycle while full.
    do_reset("reset_coll");
    request(8'h11, 0, "coll_f1");
    request(8'h22, 0, "coll_f2");
    request(8'h33, 0, "coll_f3");
    request(8'h44, 0, "coll_f4");
    chk("coll_full_before", full, 1);
    request(8'h3C, 1, "coll_push");
    chk("coll_ovf", overflow, 0);
    chk("coll_level", level, 4);
    chk("coll_full", full, 1);
    drain({8'h22, 8'h33, 8'h44, 8'h3C}, "drain_coll");

    // Ready high while empty: the new word must not be popped.
    do_reset("reset_empty");
    request(8'h66, 1, "empty_push");
    chk("empty_push_level", level, 1);
    chk("empty_push_data", out_data, 8'h66);

    // Request held high for ten cycles gives one capture.
    do_reset("reset_hold");
    bus = 8'h7E;
    cap_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      acks += int'(cap_ack);
    end
    chk("hold_level_while_req", level, 1);
    cap_req = 1'b0;
    step();
    acks += int'(cap_ack);
    step();
    acks += int'(cap_ack);
    chk("hold_ack_count", acks, 1);
    chk("hold_level", level, 1);
    chk("hold_data", out_data, 8'h7E);
    request(8'h81, 0, "hold_next");
    chk("hold_next_level", level, 2);

`ifdef BUS_CAPTURE_PARITY_EN
    // Parity: matching word first, then a mismatch that is still queued.
    do_reset("reset_par");
    bus_par = 1'b0;
    request(8'h03, 0, "par_ok");
    chk("par_ok_err", par_err, 0);
    bus_par = 1'b1;
    request(8'h03, 0, "par_bad");
    chk("par_bad_err", par_err, 1);
    chk("par_bad_level", level, 2);
    chk("par_bad_data", out_data, 8'h03);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
